// File: rtl/rvfi_retire_packer_if.sv
// Retirement-record input and RVFI output bundle for rvfi_retire_packer.
// master = commit stage / sink side, slave = packer.
interface rvfi_retire_packer_if #(
  parameter int XLEN = 32,
  parameter int NRET = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_insn;
  logic [XLEN-1:0]      in_pc_rdata;
  logic [XLEN-1:0]      in_pc_wdata;
  logic                 in_trap;
  logic                 in_halt;
  logic                 in_intr;
  logic                 drain_en;

  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [32*NRET-1:0]   rvfi_insn;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata;
  logic [XLEN*NRET-1:0] rvfi_pc_wdata;
  logic [NRET-1:0]      rvfi_trap;
  logic [NRET-1:0]      rvfi_halt;
  logic [NRET-1:0]      rvfi_intr;
  logic                 rvfi_rollback_valid;
  logic                 pc_chain_err;

  modport master (
    output in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_halt, in_intr, drain_en,
    input  in_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_trap, rvfi_halt, rvfi_intr, rvfi_rollback_valid, pc_chain_err
  );

  modport slave (
    input  in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_halt, in_intr, drain_en,
    output in_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_trap, rvfi_halt, rvfi_intr, rvfi_rollback_valid, pc_chain_err
  );
endinterface

// File: rtl/rvfi_retire_packer.sv
// Buffers in-order retirement records and packs up to NRET per cycle onto RVFI channels.
// Optional PC-chain checker enabled by defining RVFI_PACKER_PC_CHAIN_CHK_EN.
module rvfi_retire_packer #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  rvfi_retire_packer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic            halt;
    logic            intr;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            ch_q  [NRET];
  logic [63:0]     order_q [NRET];
  logic [NRET-1:0] valid_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d, n;
  logic [63:0]     order_base_q;
  logic            halted_q;
  logic            live_q;
  logic            in_ready;
  logic            push;

  // live_q keeps in_ready low while in reset and until the first edge after release
  assign in_ready = live_q && (count_q != CW'(DEPTH)) && !halted_q;
  assign push     = bus.in_valid && in_ready;

  always_comb begin
    n = '0;
    if (bus.drain_en) n = (count_q < CW'(NRET)) ? count_q : CW'(NRET);
  end

  assign count_d = count_q + CW'(push) - n;

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= {bus.in_insn, bus.in_pc_rdata, bus.in_pc_wdata,
                          bus.in_trap, bus.in_halt, bus.in_intr};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      live_q       <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      order_base_q <= '0;
      halted_q     <= 1'b0;
      valid_q      <= '0;
      for (int i = 0; i < NRET; i++) begin
        ch_q[i]    <= '0;
        order_q[i] <= '0;
      end
    end else begin
      live_q       <= 1'b1;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_q + PW'(n);
      order_base_q <= order_base_q + 64'(n);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (bus.in_halt) halted_q <= 1'b1;
      end
      // idle channels keep their last data; only valid drops
      for (int i = 0; i < NRET; i++) begin
        valid_q[i] <= (CW'(i) < n);
        if (CW'(i) < n) begin
          ch_q[i]    <= mem_q[rd_ptr_q + PW'(i)];
          order_q[i] <= order_base_q + 64'(i);
        end
      end
    end
  end

  always_comb begin
    bus.rvfi_order    = '0;
    bus.rvfi_insn     = '0;
    bus.rvfi_pc_rdata = '0;
    bus.rvfi_pc_wdata = '0;
    bus.rvfi_trap     = '0;
    bus.rvfi_halt     = '0;
    bus.rvfi_intr     = '0;
    for (int i = 0; i < NRET; i++) begin
      bus.rvfi_order[64*i +: 64]      = order_q[i];
      bus.rvfi_insn[32*i +: 32]       = ch_q[i].insn;
      bus.rvfi_pc_rdata[XLEN*i +: XLEN] = ch_q[i].pc_rdata;
      bus.rvfi_pc_wdata[XLEN*i +: XLEN] = ch_q[i].pc_wdata;
      bus.rvfi_trap[i]                = ch_q[i].trap;
      bus.rvfi_halt[i]                = ch_q[i].halt;
      bus.rvfi_intr[i]                = ch_q[i].intr;
    end
  end

  assign bus.in_ready            = in_ready;
  assign bus.rvfi_valid          = valid_q;
  assign bus.rvfi_rollback_valid = 1'b0;

`ifdef RVFI_PACKER_PC_CHAIN_CHK_EN
  logic [XLEN-1:0] last_pc_wdata_q;
  logic            last_valid_q;
  logic            chain_err_q;

  // interrupts legitimately redirect the PC, so they are exempt from the chain check
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_pc_wdata_q <= '0;
      last_valid_q    <= 1'b0;
      chain_err_q     <= 1'b0;
    end else if (push) begin
      last_pc_wdata_q <= bus.in_pc_wdata;
      last_valid_q    <= 1'b1;
      if (last_valid_q && !bus.in_intr && (bus.in_pc_rdata != last_pc_wdata_q))
        chain_err_q <= 1'b1;
    end
  end

  assign bus.pc_chain_err = chain_err_q;
`else
  assign bus.pc_chain_err = 1'b0;
`endif

endmodule
